// File: rtl/riscv_m_pkg.sv
// Shared definitions for the RV M-extension execute unit: FSM states and
// instruction field encodings.
package riscv_m_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } m_state_e;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/riscv_m_unit_param_mult.sv
// Pipelined (XLEN+1)x(XLEN+1) signed multiplier. The product is formed at the
// input and carried through MUL_STAGES retiming registers with a valid chain.
module m_mult_pipe #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                i_valid,
  input  logic [XLEN:0]       i_a,
  input  logic [XLEN:0]       i_b,
  output logic                o_valid,
  output logic [2*XLEN+1:0]   o_product
);

  localparam int PW = 2 * XLEN + 2;

  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  logic        [PW-1:0] w_prod;
  logic        [PW-1:0] w_stage_in [MUL_STAGES];
  logic        [MUL_STAGES-1:0] w_vld_in;
  logic        [PW-1:0] r_stage [MUL_STAGES];
  logic        [MUL_STAGES-1:0] r_vld;

  assign w_a_ext = PW'($signed(i_a));
  assign w_b_ext = PW'($signed(i_b));
  assign w_prod  = w_a_ext * w_b_ext;

  // Stage 0 takes the fresh product; later stages take their predecessor.
  genvar g;
  generate
    for (g = 0; g < MUL_STAGES; g++) begin : g_chain
      if (g == 0) begin : g_first
        assign w_stage_in[g] = w_prod;
        assign w_vld_in[g]   = i_valid;
      end else begin : g_next
        assign w_stage_in[g] = r_stage[g-1];
        assign w_vld_in[g]   = r_vld[g-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      for (int i = 0; i < MUL_STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_vld <= flush ? '0 : w_vld_in;
      for (int i = 0; i < MUL_STAGES; i++) r_stage[i] <= w_stage_in[i];
    end
  end

  assign o_valid   = r_vld[MUL_STAGES-1];
  assign o_product = r_stage[MUL_STAGES-1];

endmodule

// File: rtl/riscv_m_unit_param.sv
// RV M-extension execute unit: pipelined multiply, radix-2 restoring divide
// with single-cycle early-out for divide-by-zero and signed overflow.
module riscv_m_unit_param
  import riscv_m_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            ready,
  output logic            wr,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_dest,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  // Handshake: an op is taken when valid && M-op && IDLE && !flush; the
  // result is presented for exactly one cycle with ready == wr == 1.
  m_state_e r_state, w_next;

  logic [2:0]      w_f3;
  logic            w_is_mop, w_accept, w_is_div, w_signed_div;
  logic            w_rs2_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_special_res, w_abs_a, w_abs_b;
  logic [XLEN:0]   w_mul_a, w_mul_b;
  logic            w_mul_vld;
  logic [2*XLEN+1:0] w_prod;
  logic [XLEN-1:0] w_mul_res;

  logic [XLEN-1:0] r_quot, r_rem, r_divisor, r_result;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q, r_neg_r, r_is_rem, r_mul_lo;
  logic [4:0]      r_rd;

  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_sub;
  logic            w_ge;
  logic [XLEN-1:0] w_quot_next, w_rem_next, w_q_fix, w_r_fix, w_div_res;
  logic            w_out_en;
  logic            w_unused_bits;

  assign w_f3         = instruction[14:12];
  assign w_is_mop     = (instruction[6:0] == OPCODE_OP) && (instruction[31:25] == FUNCT7_MULDIV);
  assign w_accept     = valid && w_is_mop && (r_state == S_IDLE) && !flush;
  assign w_is_div     = w_f3[2];
  assign w_signed_div = !w_f3[0];

  assign w_rs2_zero = (rs2 == '0);
  assign w_ovf      = w_signed_div && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign w_special  = w_is_div && (w_rs2_zero || w_ovf);

  always_comb begin
    w_special_res = '0;
    if (w_rs2_zero) w_special_res = w_f3[1] ? rs1 : '1;
    else            w_special_res = w_f3[1] ? '0  : rs1;
  end

  assign w_abs_a = (w_signed_div && rs1[XLEN-1]) ? -rs1 : rs1;
  assign w_abs_b = (w_signed_div && rs2[XLEN-1]) ? -rs2 : rs2;

  // rs1 is signed for all but MULHU; rs2 is signed only for MUL/MULH.
  assign w_mul_a = {(w_f3[1:0] != FUNCT3_MULHU[1:0]) && rs1[XLEN-1], rs1};
  assign w_mul_b = {!w_f3[1] && rs2[XLEN-1], rs2};

  m_mult_pipe #(
    .XLEN       (XLEN),
    .MUL_STAGES (MUL_STAGES)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .i_valid   (w_accept && !w_is_div),
    .i_a       (w_mul_a),
    .i_b       (w_mul_b),
    .o_valid   (w_mul_vld),
    .o_product (w_prod)
  );

  assign w_mul_res = r_mul_lo ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_shift     = {r_rem, r_quot[XLEN-1]};
  assign w_sub       = {1'b0, w_shift} - {2'b00, r_divisor};
  assign w_ge        = !w_sub[XLEN+1];
  assign w_rem_next  = w_ge ? w_sub[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quot_next = {r_quot[XLEN-2:0], w_ge};
  assign w_q_fix     = r_neg_q ? -w_quot_next : w_quot_next;
  assign w_r_fix     = r_neg_r ? -w_rem_next  : w_rem_next;
  assign w_div_res   = r_is_rem ? w_r_fix : w_q_fix;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = !w_is_div ? S_MUL : (w_special ? S_DONE : S_DIV);
      S_MUL:  if (w_mul_vld) w_next = S_DONE;
      S_DIV:  if (r_cnt == LAST_ITER) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_rem  <= 1'b0;
      r_mul_lo  <= 1'b0;
      r_rd      <= '0;
    end else if (w_accept) begin
      r_rd      <= instruction[11:7];
      r_is_rem  <= w_f3[1];
      r_mul_lo  <= (w_f3[1:0] == FUNCT3_MUL[1:0]);
      r_neg_q   <= w_signed_div && (rs1[XLEN-1] ^ rs2[XLEN-1]);
      r_neg_r   <= w_signed_div && rs1[XLEN-1];
      r_quot    <= w_abs_a;
      r_rem     <= '0;
      r_divisor <= w_abs_b;
      r_cnt     <= '0;
      if (w_special) r_result <= w_special_res;
    end else if (r_state == S_DIV) begin
      r_quot <= w_quot_next;
      r_rem  <= w_rem_next;
      r_cnt  <= r_cnt + CW'(1);
      if (r_cnt == LAST_ITER) r_result <= w_div_res;
    end else if (r_state == S_MUL && w_mul_vld) begin
      r_result <= w_mul_res;
    end
  end

  assign w_out_en    = (r_state == S_DONE) && !flush;
  assign busy        = (r_state != S_IDLE);
  assign ready       = w_out_en;
  assign wr          = w_out_en;
  assign result      = w_out_en ? r_result : '0;
  assign result_dest = w_out_en ? r_rd : '0;
  assign dbg_state   = r_state;

  assign w_unused_bits = ^{instruction[24:15], w_prod[2*XLEN+1:2*XLEN], w_sub[XLEN]};

endmodule

// File: tb/tb_riscv_m_unit_param.sv
// Self-checking bench for riscv_m_unit_param (XLEN=32, MUL_STAGES=2): directed
// corner cases followed by random ops checked against an arithmetic model.
module tb_riscv_m_unit_param;
  import riscv_m_pkg::*;

  localparam int XLEN       = 32;
  localparam int MUL_STAGES = 2;

  logic            clk = 1'b0;
  logic            reset, valid, flush;
  logic [31:0]     instruction;
  logic [XLEN-1:0] rs1, rs2;
  logic            busy, ready, wr;
  logic [XLEN-1:0] result;
  logic [4:0]      result_dest;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [XLEN-1:0] exp_q[$];

  riscv_m_unit_param #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
    .clk(clk), .reset(reset), .valid(valid), .instruction(instruction),
    .rs1(rs1), .rs2(rs2), .flush(flush), .busy(busy), .ready(ready), .wr(wr),
    .result(result), .result_dest(result_dest), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // reference model: plain 64-bit arithmetic straight from the M-extension rules
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, p, q;
    longint unsigned ua_u, ub_u, pu;
    bit ovf;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'd0, b});
    ua_u = {32'd0, a};
    ub_u = {32'd0, b};
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = ua_u * ub_u; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_STAGES + 1;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // driver: called at a negedge, returns at a negedge one cycle after ready
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    int lat, got;
    logic [XLEN-1:0] exp;
    exp_q.push_back(ref_result(f3, a, b));
    lat = ref_latency(f3, a, b);
    valid = 1'b1; instruction = mk_instr(f3, rd); rs1 = a; rs2 = b;
    @(posedge clk);
    got = 0;
    for (int c = 1; c <= XLEN + 8; c++) begin
      @(negedge clk);
      valid = 1'b0;
      if (c == 1) check({tag, " busy"}, busy, 1'b1);
      if (ready) begin got = c; break; end
    end
    exp = exp_q.pop_front();
    check({tag, " latency"}, got, lat);
    if (got != 0) begin
      check({tag, " result"}, result, exp);
      check({tag, " dest"}, result_dest, rd);
      check({tag, " wr"}, wr, 1'b1);
    end
    @(negedge clk);
    check({tag, " idle after"}, {busy, ready, wr}, 3'b000);
  endtask

  initial begin : main
    bit saw_ready;
    reset = 1'b1; valid = 1'b0; flush = 1'b0;
    instruction = '0; rs1 = '0; rs2 = '0;
    #12;
    check("reset outputs", {busy, ready, wr, result, result_dest}, '0);
    check("reset state", dbg_state, S_IDLE);
    @(negedge clk);
    reset = 1'b0;

    run_op("mulh_minmin",  3'd1, 32'h8000_0000, 32'h8000_0000, 5'd5);
    run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    run_op("mul_m1",       3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    run_op("divu_zero",    3'd5, 32'd5, 32'd0, 5'd10);
    run_op("rem_zero",     3'd6, 32'd7, 32'd0, 5'd11);
    run_op("div_neg",      3'd4, -32'sd7, 32'd2, 5'd12);
    run_op("rem_neg",      3'd6, -32'sd7, 32'd2, 5'd13);
    run_op("divu_100_7",   3'd5, 32'd100, 32'd7, 5'd14);

    // flush partway through a divide
    saw_ready = 1'b0;
    valid = 1'b1; instruction = mk_instr(3'd5, 5'd15); rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      valid = 1'b0;
      saw_ready |= (ready | wr);
      if (i == 5) check("div state", dbg_state, S_DIV);
      if (i == 10) flush = 1'b1;
    end
    @(negedge clk);
    saw_ready |= (ready | wr);
    flush = 1'b0;
    check("flush busy", busy, 1'b0);
    check("flush no ready", saw_ready, 1'b0);
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd16);

    // flush landing on the DONE cycle
    valid = 1'b1; instruction = mk_instr(3'd0, 5'd3); rs1 = 32'd5; rs2 = 32'd6;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 flush = 1'b1;
    #1;
    check("done flush outputs", {ready, wr, result, result_dest}, '0);
    check("done flush busy", busy, 1'b1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("done flush idle", {busy, ready}, 2'b00);

    // asynchronous reset mid-divide
    valid = 1'b1; instruction = mk_instr(3'd4, 5'd4); rs1 = -32'sd7; rs2 = 32'd2;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      valid = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    check("async reset outputs", {busy, ready, wr, result, result_dest}, '0);
    check("async reset state", dbg_state, S_IDLE);
    @(negedge clk);
    reset = 1'b0;
    valid = 1'b1;
    instruction = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011};
    rs1 = 32'd1; rs2 = 32'd2;
    repeat (3) begin
      @(negedge clk);
      check("add ignored", busy, 1'b0);
    end
    valid = 1'b0;

    // randomized ops against the model
    for (int n = 0; n < 40; n++) begin
      logic [2:0] f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rand%0d_f3_%0d", n, f3), f3, a, b, 5'($urandom_range(1, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
